cim_weight_loader: RTL

- Initiator-side controller for the CIM unit's weight-storage (STD) port.
- Accepts a load command plus a valid/ready stream of weight rows, and drives STDW / STD_Core_A / STD_row_A / weight_in to fill one core row-by-row.
- Optionally reads the rows back over STDR/weight_out and checks a signature.
- Replaces hand-sequenced STD traffic upstream of CIM_Unit.

---
 rtl/cim_pkg.sv | 24 ++
 rtl/cim_weight_loader_if.sv | 34 +++
 rtl/cim_sig_acc.sv | 21 ++
 rtl/cim_weight_loader.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// Shared constants and state encoding for the CIM weight loader.
package cim_pkg;

    localparam int CIM_ROWS     = 64;
    localparam int CIM_ROW_AW   = 6;
    localparam int CIM_CORE_AW  = 3;
    localparam int CIM_WEIGHT_W = 288;
    localparam int CIM_READ_LAT = 1;

    localparam logic [CIM_ROW_AW:0] CIM_ROWS_CNT = (CIM_ROW_AW+1)'(CIM_ROWS);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CHECK,
        FINISH
    } wl_state_e;

    function automatic logic rows_legal(input logic [CIM_ROW_AW:0] rows);
        return (rows != '0) && (rows <= CIM_ROWS_CNT);
    endfunction

endpackage

// File: rtl/cim_weight_loader_if.sv
// Command, weight stream and STD port of the weight loader; the loader side uses the slave modport.
interface cim_weight_loader_if;
    import cim_pkg::*;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [CIM_CORE_AW-1:0]  cmd_core;
    logic [CIM_ROW_AW:0]     cmd_rows;
    logic                    w_valid;
    logic                    w_ready;
    logic [CIM_WEIGHT_W-1:0] w_data;
    logic                    STDW;
    logic                    STDR;
    logic [CIM_CORE_AW-1:0]  STD_Core_A;
    logic [CIM_ROW_AW-1:0]   STD_row_A;
    logic [CIM_WEIGHT_W-1:0] weight_in;
    logic [CIM_WEIGHT_W-1:0] weight_out;
    logic                    busy;
    logic                    done;
    logic                    err;

    modport master (
        output cmd_valid, cmd_core, cmd_rows, w_valid, w_data, weight_out,
        input  cmd_ready, w_ready, STDW, STDR, STD_Core_A, STD_row_A, weight_in,
        input  busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_core, cmd_rows, w_valid, w_data, weight_out,
        output cmd_ready, w_ready, STDW, STDR, STD_Core_A, STD_row_A, weight_in,
        output busy, done, err
    );

endinterface

// File: rtl/cim_sig_acc.sv
// Row-wide XOR signature accumulator; clear wins over enable, result available the cycle after each fold.
module cim_sig_acc
    import cim_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic [CIM_WEIGHT_W-1:0] din,
    output logic [CIM_WEIGHT_W-1:0] sig
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= sig ^ din;
        end
    end

endmodule

// File: rtl/cim_weight_loader.sv
// Fills one CIM core row-by-row from a weight stream; all STD outputs are registered (one cycle after each beat).
// Optional readback signature check is built when CIM_WL_VERIFY_EN is defined.
module cim_weight_loader
    import cim_pkg::*;
(
    input  logic clk,
    input  logic rst,
    cim_weight_loader_if.slave bus
);

    wl_state_e           state;
    wl_state_e           state_nxt;
    logic [CIM_ROW_AW:0] n_rows;
    logic [CIM_ROW_AW:0] row_cnt;
    logic                idle;
    logic                wr_open;
    logic                cmd_fire;
    logic                rows_ok;
    logic                beat_fire;
    logic                last_beat;

    assign idle      = (state == IDLE);
    assign wr_open   = (state == WRITE) && (row_cnt < n_rows);
    assign cmd_fire  = bus.cmd_valid && idle;
    assign rows_ok   = rows_legal(bus.cmd_rows);
    assign beat_fire = bus.w_valid && wr_open;
    assign last_beat = beat_fire && (row_cnt == n_rows - 1'b1);

`ifdef CIM_WL_VERIFY_EN
    logic [CIM_ROW_AW:0]     rd_cnt;
    logic [CIM_ROW_AW:0]     smp_cnt;
    logic [CIM_READ_LAT-1:0] rd_pipe;
    logic                    rd_issue;
    logic                    smp_fire;
    logic                    last_smp;
    logic [CIM_WEIGHT_W-1:0] sig_w;
    logic [CIM_WEIGHT_W-1:0] sig_r;

    assign rd_issue = (state == READ) && (rd_cnt < n_rows);
    assign smp_fire = rd_pipe[CIM_READ_LAT-1];
    assign last_smp = smp_fire && (smp_cnt == n_rows - 1'b1);

    cim_sig_acc u_sig_w (
        .clk (clk),
        .rst (rst),
        .clr (cmd_fire),
        .en  (beat_fire),
        .din (bus.w_data),
        .sig (sig_w)
    );

    cim_sig_acc u_sig_r (
        .clk (clk),
        .rst (rst),
        .clr (cmd_fire),
        .en  (smp_fire),
        .din (bus.weight_out),
        .sig (sig_r)
    );

    // rd_pipe marks the cycle in which each read's weight_out is valid
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.STDR <= 1'b0;
            rd_cnt   <= '0;
            smp_cnt  <= '0;
            rd_pipe  <= '0;
        end else begin
            bus.STDR   <= rd_issue;
            rd_pipe[0] <= bus.STDR;
            for (int i = 1; i < CIM_READ_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            if (cmd_fire) begin
                rd_cnt  <= '0;
                smp_cnt <= '0;
            end else begin
                if (rd_issue) rd_cnt  <= rd_cnt + 1'b1;
                if (smp_fire) smp_cnt <= smp_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_readback;
    assign unused_readback = ^bus.weight_out;
    assign bus.STDR = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = idle;
        bus.w_ready   = wr_open;
        bus.busy      = !idle;
        unique case (state)
            IDLE: begin
                if (cmd_fire && rows_ok) state_nxt = WRITE;
            end
            WRITE: begin
`ifdef CIM_WL_VERIFY_EN
                if (last_beat) state_nxt = READ;
`else
                if (last_beat) state_nxt = FINISH;
`endif
            end
            READ: begin
`ifdef CIM_WL_VERIFY_EN
                if (last_smp) state_nxt = CHECK;
`else
                state_nxt = IDLE;
`endif
            end
            CHECK:   state_nxt = IDLE;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            n_rows         <= '0;
            row_cnt        <= '0;
            bus.STDW       <= 1'b0;
            bus.STD_Core_A <= '0;
            bus.STD_row_A  <= '0;
            bus.weight_in  <= '0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            state    <= state_nxt;
            bus.STDW <= beat_fire;
            // illegal commands complete immediately; legal ones finish from FINISH or CHECK
            bus.done <= (state == FINISH) || (state == CHECK) || (cmd_fire && !rows_ok);
            if (cmd_fire) begin
                bus.err <= !rows_ok;
                n_rows  <= bus.cmd_rows;
                row_cnt <= '0;
                if (rows_ok) bus.STD_Core_A <= bus.cmd_core;
            end
            if (beat_fire) begin
                bus.STD_row_A <= row_cnt[CIM_ROW_AW-1:0];
                bus.weight_in <= bus.w_data;
                row_cnt       <= row_cnt + 1'b1;
            end
`ifdef CIM_WL_VERIFY_EN
            if (rd_issue) bus.STD_row_A <= rd_cnt[CIM_ROW_AW-1:0];
            if (state == CHECK) bus.err <= (sig_w != sig_r);
`endif
        end
    end

endmodule
